sticky_or_reduce: RTL and testbench
===================================

// Module: sticky_or_reduce
// PURPOSE
//  Pipelined, parametrised OR-reduction producing the sticky and any-set bits for FP rounding.
//  Sits after the 106-bit Vedic mantissa product, ahead of round/normalise in the DP multiplier.
//  Masks the product to its low in_cut bits, then reduces by CHUNK-input ORs per registered level.
//  Valid/ready on both sides.
// PARAMETERS
//  WIDTH   106                   input vector width (53x53 mantissa product)
//  CHUNK   8                     OR fan-in per pipeline level (>=2)
//  CUT_W   $clog2(WIDTH+1)       width of in_cut
//  LEVELS  fp_mul_pkg::or_levels(WIDTH,CHUNK)  derived, not overridable; 3 at defaults
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  in_valid    in   1      input beat valid
//  in_ready    out  1      block accepts beat this cycle
//  in_data     in   WIDTH  vector to reduce
//  in_cut      in   CUT_W  count of low bits feeding sticky (bits [in_cut-1:0])
//  in_last     in   1      end of accumulation group (only with SEG_ACCUM_EN)
//  out_valid   out  1      result valid
//  out_ready   in   1      downstream accepts result
//  out_sticky  out  1      |in_data[in_cut-1:0]
//  out_any     out  1      |in_data[WIDTH-1:0]
// BEHAVIOUR
//  - Reset: every stage valid bit, partial-OR register, out_valid, out_sticky and out_any go to 0.
//    in_ready is 1 one cycle after reset release.
//  - adv = !out_valid || out_ready. in_ready = adv. When adv=1, all LEVELS stages shift together.
//    When adv=0, all stages hold. Beat is accepted on in_valid && in_ready.
//  - Bubbles are not collapsed: a stage with valid=0 still shifts when adv=1.
//  - Latency: LEVELS cycles from acceptance to out_valid when not stalled. Throughput 1 beat/cycle.
//  - Level 0: mask bit i = (i < in_cut).
//    Registers ceil(WIDTH/CHUNK) sticky partials and the same number of any partials.
//    The top chunk is zero-padded.
//  - Level k: registers ceil(prev/CHUNK) partials. The final level holds 1 bit each.
//  - in_cut >= WIDTH saturates: sticky equals any. in_cut=0 forces sticky=0.
//  - out_* hold stable while out_valid && !out_ready (AXI-style). Data never drops or duplicates.
//  - in_valid must not be required to stay high. Deasserting without a handshake is legal.
//  - Async reset mid-operation discards all in-flight beats. No output for them after release.
// CONFIGURATION
//  SEG_ACCUM_EN defined:
//   - in_last port exists. An output accumulator ORs each beat's final-level sticky and any.
//   - out_valid rises only for beats with in_last=1.
//     out_sticky/out_any = OR over all beats since the previous last beat, inclusive.
//   - Non-last beats consume pipeline slots but produce no output. The accumulator clears on output handshake.
//   - Reset clears the accumulator.
//  SEG_ACCUM_EN undefined:
//   - in_last port absent. Every accepted beat yields exactly one output.
// STRUCTURE
//  - fp_mul_pkg holds:
//    - default WIDTH/CHUNK localparams
//    - function or_levels(width,chunk) and function or_parts(width,chunk,level)
//    - typedef sticky_res_t {logic sticky; logic any;}
//  - Sub-module or_reduce_stage:
//    - params IN_N and CHUNK; ports clk, rst, adv, valid in/out
//    - IN_N sticky/any bits in, ceil(IN_N/CHUNK) out; registered
//    - Instantiated LEVELS times via generate.
//  - Top holds the mask, the handshake logic and the optional accumulator.
// TESTING
//  - Reset: rst high with in_valid=1 -> out_valid=0, out_sticky=0, out_any=0. in_ready=1 one cycle after release.
//  - Masking at defaults:
//    - in_data=1<<52, in_cut=52 -> sticky=0, any=1, after 3 cycles.
//    - in_cut=53 -> sticky=1.
//    - in_data=0, in_cut=106 -> sticky=0, any=0.
//  - Saturation and edge bits:
//    - in_cut=127, in_data=1<<105 -> sticky=1, any=1.
//    - in_cut=0, in_data=all-ones -> sticky=0, any=1.
//  - Backpressure:
//    - Send 6 back-to-back beats with out_ready=0 for cycles 4-8 -> in_ready=0 while stalled.
//    - Outputs hold stable; all 6 results emerge in order, none lost.
//  - Reset mid-flight: accept 2 beats, assert rst at cycle 2 -> no out_valid ever for those beats.
//  - SEG_ACCUM_EN: send 3 beats with sticky contributions 0,1,0, last on the third -> one output, sticky=1.
//    Then a single last beat with contribution 0 -> sticky=0.
//  - Random: 10k beats with random in_cut, in_data, out_ready -> matches the scoreboard OR model in both configs.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared sizing helpers and the sticky/any result type used by the OR-reduction tree
// that sits between the mantissa multiplier and the rounding logic.
package fp_mul_pkg;

   localparam int DEF_WIDTH = 106;
   localparam int DEF_CHUNK = 8;

   typedef struct packed {
      logic sticky;
      logic any;
   } sticky_res_t;

   // Number of partial ORs registered by pipeline level 'level' (level 0 reduces the raw vector).
   function automatic int or_parts(input int width, input int chunk, input int level);
      int n;
      n = width;
      for (int l = 0; l <= level; l++) begin
         n = (n + chunk - 1) / chunk;
      end
      return n;
   endfunction

   // Levels needed until a single bit remains; at least one so the result is always registered.
   function automatic int or_levels(input int width, input int chunk);
      int n;
      int l;
      n = (width + chunk - 1) / chunk;
      l = 1;
      while (n > 1) begin
         n = (n + chunk - 1) / chunk;
         l++;
      end
      return l;
   endfunction

   // Node index 0 is the masked input vector; node k+1 is the output of level k.
   function automatic int node_count(input int width, input int chunk, input int idx);
      return (idx == 0) ? width : or_parts(width, chunk, idx - 1);
   endfunction

   function automatic int node_offset(input int width, input int chunk, input int idx);
      int off;
      off = 0;
      for (int j = 0; j < idx; j++) begin
         off += node_count(width, chunk, j);
      end
      return off;
   endfunction

endpackage

// File: rtl/or_reduce_stage.sv
// One registered level of the OR tree: folds IN_N sticky/any bits into ceil(IN_N/CHUNK)
// partials, shifting only when the whole pipeline advances.
module or_reduce_stage
   import fp_mul_pkg::*;
#(
   parameter int  IN_N  = DEF_WIDTH,
   parameter int  CHUNK = DEF_CHUNK,
   localparam int OUT_N = (IN_N + CHUNK - 1) / CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv_i,
   input  logic             valid_i,
   input  logic [IN_N-1:0]  sticky_i,
   input  logic [IN_N-1:0]  any_i,
   output logic             valid_o,
   output logic [OUT_N-1:0] sticky_o,
   output logic [OUT_N-1:0] any_o
);

   localparam int PAD_N = OUT_N * CHUNK;

   logic [PAD_N-1:0] sticky_pad;
   logic [PAD_N-1:0] any_pad;
   logic [OUT_N-1:0] sticky_d;
   logic [OUT_N-1:0] any_d;
   logic [OUT_N-1:0] sticky_q;
   logic [OUT_N-1:0] any_q;
   logic             valid_q;

   // The top chunk is zero-padded so every partial is a full CHUNK-wide OR.
   always_comb begin
      sticky_pad             = '0;
      any_pad                = '0;
      sticky_d               = '0;
      any_d                  = '0;
      sticky_pad[IN_N-1:0]   = sticky_i;
      any_pad[IN_N-1:0]      = any_i;
      for (int p = 0; p < OUT_N; p++) begin
         sticky_d[p] = |sticky_pad[p*CHUNK +: CHUNK];
         any_d[p]    = |any_pad[p*CHUNK +: CHUNK];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         sticky_q <= '0;
         any_q    <= '0;
      end else if (adv_i) begin
         valid_q  <= valid_i;
         sticky_q <= sticky_d;
         any_q    <= any_d;
      end
   end

   assign valid_o  = valid_q;
   assign sticky_o = sticky_q;
   assign any_o    = any_q;

endmodule

// File: rtl/sticky_or_reduce.sv
// Pipelined masked OR-reduction producing the sticky and any-set bits for FP rounding.
// Define SEG_ACCUM_EN to add in_last and accumulate results across a beat group.
module sticky_or_reduce
   import fp_mul_pkg::*;
#(
   parameter int  WIDTH  = DEF_WIDTH,
   parameter int  CHUNK  = DEF_CHUNK,
   parameter int  CUT_W  = $clog2(WIDTH + 1),
   localparam int LEVELS = or_levels(WIDTH, CHUNK)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic [CUT_W-1:0] in_cut_i,
`ifdef SEG_ACCUM_EN
   input  logic             in_last_i,
`endif
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             out_sticky_o,
   output logic             out_any_o
);

   localparam int NODE_TOT = node_offset(WIDTH, CHUNK, LEVELS + 1);

   // Flat node buses: slice k holds the inputs of level k, the final bit is the tree root.
   wire [NODE_TOT-1:0] sticky_bus;
   wire [NODE_TOT-1:0] any_bus;
   wire [LEVELS:0]     vld_bus;

   logic [WIDTH-1:0] masked;
   logic             adv;
   logic             pipe_vld;
   sticky_res_t      pipe_res;

   // Only bits below in_cut feed sticky; in_cut >= WIDTH therefore keeps every bit.
   always_comb begin
      masked = '0;
      for (int i = 0; i < WIDTH; i++) begin
         masked[i] = in_data_i[i] && (i < int'(in_cut_i));
      end
   end

   assign sticky_bus[WIDTH-1:0] = masked;
   assign any_bus[WIDTH-1:0]    = in_data_i;
   assign vld_bus[0]            = in_valid_i && in_ready_o;

   for (genvar k = 0; k < LEVELS; k++) begin : gen_lvl
      localparam int IN_OFF  = node_offset(WIDTH, CHUNK, k);
      localparam int IN_N    = node_count(WIDTH, CHUNK, k);
      localparam int OUT_OFF = node_offset(WIDTH, CHUNK, k + 1);
      localparam int OUT_N   = node_count(WIDTH, CHUNK, k + 1);

      or_reduce_stage #(
         .IN_N  (IN_N),
         .CHUNK (CHUNK)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .adv_i    (adv),
         .valid_i  (vld_bus[k]),
         .sticky_i (sticky_bus[IN_OFF +: IN_N]),
         .any_i    (any_bus[IN_OFF +: IN_N]),
         .valid_o  (vld_bus[k+1]),
         .sticky_o (sticky_bus[OUT_OFF +: OUT_N]),
         .any_o    (any_bus[OUT_OFF +: OUT_N])
      );
   end

   assign pipe_vld        = vld_bus[LEVELS];
   assign pipe_res.sticky = sticky_bus[NODE_TOT-1];
   assign pipe_res.any    = any_bus[NODE_TOT-1];

   // Handshake: valid/ready on both sides; a beat moves on valid && ready, and the whole
   // pipeline shifts in lockstep (bubbles included) whenever the output slot can drain.
   assign adv        = !out_valid_o || out_ready_i;
   assign in_ready_o = adv;

`ifdef SEG_ACCUM_EN
   logic [LEVELS-1:0] last_q;
   logic [LEVELS-1:0] last_d;
   logic              acc_sticky_q;
   logic              acc_sticky_d;
   logic              acc_any_q;
   logic              acc_any_d;

   // Non-last beats leave the final stage into the accumulator; a last beat is presented
   // merged with it and the accumulator clears when that result is taken.
   always_comb begin
      last_d       = last_q;
      acc_sticky_d = acc_sticky_q;
      acc_any_d    = acc_any_q;
      if (adv) begin
         last_d[0] = in_last_i;
         for (int k = 1; k < LEVELS; k++) begin
            last_d[k] = last_q[k-1];
         end
         if (pipe_vld) begin
            if (last_q[LEVELS-1]) begin
               acc_sticky_d = 1'b0;
               acc_any_d    = 1'b0;
            end else begin
               acc_sticky_d = acc_sticky_q | pipe_res.sticky;
               acc_any_d    = acc_any_q | pipe_res.any;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q       <= '0;
         acc_sticky_q <= 1'b0;
         acc_any_q    <= 1'b0;
      end else begin
         last_q       <= last_d;
         acc_sticky_q <= acc_sticky_d;
         acc_any_q    <= acc_any_d;
      end
   end

   assign out_valid_o  = pipe_vld && last_q[LEVELS-1];
   assign out_sticky_o = out_valid_o && (acc_sticky_q || pipe_res.sticky);
   assign out_any_o    = out_valid_o && (acc_any_q || pipe_res.any);
`else
   assign out_valid_o  = pipe_vld;
   assign out_sticky_o = out_valid_o && pipe_res.sticky;
   assign out_any_o    = out_valid_o && pipe_res.any;
`endif

endmodule

// File: tb/tb_sticky_or_reduce.sv
// Directed and randomized self-checking bench for sticky_or_reduce; compile with
// SEG_ACCUM_EN defined to cover the segment-accumulation variant as well.
module tb_sticky_or_reduce;
   import fp_mul_pkg::*;

   localparam int W  = DEF_WIDTH;
   localparam int CW = $clog2(W + 1);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [CW-1:0] in_cut;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic          out_sticky;
   logic          out_any;

   sticky_or_reduce dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .in_cut_i     (in_cut),
`ifdef SEG_ACCUM_EN
      .in_last_i    (in_last),
`endif
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_sticky_o (out_sticky),
      .out_any_o    (out_any)
   );

   // ---------------- scoreboard state ----------------
   int         checks   = 0;
   int         failures = 0;
   int         out_cnt  = 0;
   logic [1:0] exp_q[$];          // {sticky, any}
   logic [1:0] m_acc     = 2'b00;
   logic       prev_stall = 1'b0;
   logic [1:0] prev_res   = 2'b00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: sticky covers the low in_cut bits, built from a shifted mask.
   function automatic logic [1:0] ref_res(input logic [W-1:0] d, input logic [CW-1:0] c);
      logic [W-1:0] m;
      if (int'(c) >= W) m = '1;
      else              m = (W'(1) << c) - W'(1);
      return {|(d & m), |d};
   endfunction

   function automatic logic [W-1:0] rand_data();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return W'(1) << $urandom_range(0, W - 1);
         2:       return r[W-1:0] & {$urandom, $urandom, $urandom, $urandom} & W'({4{$urandom}});
         default: return r[W-1:0];
      endcase
   endfunction

   // Monitor: checks output order/value, AXI-style hold, and records accepted beats.
   always @(negedge clk) begin
      logic [1:0] e;
      logic [1:0] r;
      if (rst) begin
         exp_q.delete();
         m_acc      = 2'b00;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", {out_sticky, out_any}, prev_res);
         end
         if (out_valid && out_ready) begin
            check("out_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_data", {out_sticky, out_any}, e);
            end
            out_cnt++;
         end
         prev_stall = out_valid && !out_ready;
         prev_res   = {out_sticky, out_any};
         if (in_valid && in_ready) begin
            r = ref_res(in_data, in_cut);
`ifdef SEG_ACCUM_EN
            m_acc = m_acc | r;
            if (in_last) begin
               exp_q.push_back(m_acc);
               m_acc = 2'b00;
            end
`else
            exp_q.push_back(r);
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   // One isolated beat with hand-computed result; checks the 3-cycle latency exactly.
   task automatic run_one(input string tag, input logic [W-1:0] d, input logic [CW-1:0] c,
                          input logic es, input logic ea);
      in_valid  = 1'b1;
      in_data   = d;
      in_cut    = c;
      in_last   = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_lat1"}, out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_lat2"}, out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_sticky"}, out_sticky, es);
      check({tag, "_any"}, out_any, ea);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int   idx;
      int   base;
      int   sent;
      int   cyc;
      logic acc;
      logic found;

      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = '1;
      in_cut    = CW'(W);
      in_last   = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sticky", out_sticky, 0);
      check("rst_out_any", out_any, 0);
      @(posedge clk); #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_ready_after", in_ready, 1);
      check("rst_no_output", out_valid, 0);

      run_one("cut52_bit52", W'(1) << 52, CW'(52), 1'b0, 1'b1);
      run_one("cut53_bit52", W'(1) << 52, CW'(53), 1'b1, 1'b1);
      run_one("zero_cut106", '0, CW'(106), 1'b0, 1'b0);
      run_one("cut127_bit105", W'(1) << 105, CW'(127), 1'b1, 1'b1);
      run_one("cut105_bit105", W'(1) << 105, CW'(105), 1'b0, 1'b1);
      run_one("cut0_ones", '1, CW'(0), 1'b0, 1'b1);
      run_one("cut1_bit0", W'(1), CW'(1), 1'b1, 1'b1);

      // Backpressure: 6 back-to-back beats, out_ready low for cycles 4..8.
      idx  = 0;
      base = out_cnt;
      for (int c = 0; c < 20; c++) begin
         in_valid  = (idx < 6);
         in_data   = rand_data();
         in_cut    = CW'($urandom_range(0, 127));
         in_last   = 1'b1;
         out_ready = !(c >= 4 && c <= 8);
         @(negedge clk);
         if (c >= 4 && c <= 8) check("bp_ready_low", in_ready, 0);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_all_sent", idx, 6);
      check("bp_all_out", out_cnt - base, 6);
      check("bp_queue_empty", exp_q.size(), 0);

`ifdef SEG_ACCUM_EN
      // Group of three beats contributing sticky 0,1,0 -> single output, sticky=1.
      base = out_cnt;
      for (int b = 0; b < 3; b++) begin
         in_valid = 1'b1;
         in_data  = (b == 2) ? '0 : (W'(1) << 52);
         in_cut   = (b == 1) ? CW'(53) : CW'(52);
         in_last  = (b == 2);
         @(negedge clk);
         check("seg_ready", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      found    = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (out_valid) found = 1'b1;
      end
      check("seg_found", found, 1);
      check("seg_sticky", out_sticky, 1);
      check("seg_any", out_any, 1);
      @(posedge clk); #1;
      idle(5);
      check("seg_one_output", out_cnt - base, 1);
      run_one("seg_single_last", W'(1) << 52, CW'(52), 1'b0, 1'b1);
`endif

      // Reset mid-flight: two accepted beats must never appear.
      out_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1;
         in_data  = '1;
         in_cut   = CW'(106);
         in_last  = 1'b1;
         @(negedge clk);
         check("mid_rst_accept", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      base     = out_cnt;
      rst      = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("mid_rst_no_valid", out_valid, 0);
         @(posedge clk); #1;
      end
      check("mid_rst_no_output", out_cnt - base, 0);

      // Random traffic against the scoreboard.
      sent = 0;
      cyc  = 0;
      while (sent < 10000 && cyc < 60000) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = rand_data();
         in_cut    = CW'($urandom_range(0, 127));
         in_last   = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) sent++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("rand_sent", sent, 10000);
      check("rand_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
